// File: rtl/c2h.sv
// c2h: line-oriented ASCII command parser (D hh, I hh, R, LD, LI) producing 32-bit command words.
// Build option: define C2H_LOWERCASE_EN to accept lowercase command letters and hex digits.
module c2h #(
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned MAX_DIGITS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned DIG_W = 2;

  localparam logic [7:0] OP_I  = 8'h01;
  localparam logic [7:0] OP_R  = 8'h02;
  localparam logic [7:0] OP_LD = 8'h03;
  localparam logic [7:0] OP_LI = 8'h04;
  localparam logic [7:0] OP_D  = 8'h05;

  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GOT_L   = 3'd1,
    S_ARG     = 3'd2,
    S_NOARG   = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t             state_q, state_d, state_eff;
  logic [7:0]         opcode_q, opcode_d;
  logic [7:0]         value_q, value_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               issue, syn_err, expire, active;
  logic               cmd_valid_d, err_d, busy_d;
  logic [31:0]        cmd_word_d;

  logic [7:0]         rx_byte;
  logic               is_eol, is_sp, is_hex;
  logic [3:0]         nibble;

  // Byte folding and classification
  always_comb begin
    rx_byte = rx_data;
`ifdef C2H_LOWERCASE_EN
    if ((rx_data >= 8'h61 && rx_data <= 8'h66) || rx_data == 8'h69 ||
        rx_data == 8'h6C || rx_data == 8'h72)
      rx_byte = rx_data & 8'hDF;
`endif
    is_eol = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    is_sp  = (rx_byte == 8'h20);
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(rx_byte[3:0] + 4'd9);
    end
  end

  // Inter-byte timeout; an expiring command is treated as if the parser were already idle
  assign active = (state_q == S_GOT_L) || (state_q == S_ARG) || (state_q == S_NOARG);
  assign expire = (TIMEOUT_CYC != 0) && active && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign state_eff = expire ? S_IDLE : state_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= 8'h00;
      value_q   <= 8'h00;
      digits_q  <= '0;
      cnt_q     <= '0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_word  <= 32'h0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      value_q   <= value_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      cmd_valid <= cmd_valid_d;
      err       <= err_d;
      busy      <= busy_d;
      cmd_word  <= cmd_word_d;
    end
  end

  // Next-state and parse decisions
  always_comb begin
    state_d  = state_eff;
    opcode_d = opcode_q;
    value_d  = value_q;
    digits_d = digits_q;
    issue    = 1'b0;
    syn_err  = 1'b0;
    cnt_d    = '0;

    if ((TIMEOUT_CYC != 0) && active && !rx_valid && !expire)
      cnt_d = cnt_q + CNT_W'(1);

    if (rx_valid && !is_sp) begin
      case (state_eff)
        S_IDLE: begin
          if (!is_eol) begin
            value_d  = 8'h00;
            digits_d = '0;
            case (rx_byte)
              CH_D:    begin state_d = S_ARG;   opcode_d = OP_D; end
              CH_I:    begin state_d = S_ARG;   opcode_d = OP_I; end
              CH_R:    begin state_d = S_NOARG; opcode_d = OP_R; end
              CH_L:    state_d = S_GOT_L;
              default: begin state_d = S_DISCARD; syn_err = 1'b1; end
            endcase
          end
        end
        S_GOT_L: begin
          if (rx_byte == CH_D) begin
            state_d  = S_NOARG;
            opcode_d = OP_LD;
          end else if (rx_byte == CH_I) begin
            state_d  = S_NOARG;
            opcode_d = OP_LI;
          end else begin
            syn_err = 1'b1;
            state_d = is_eol ? S_IDLE : S_DISCARD;
          end
        end
        S_ARG: begin
          if (is_hex) begin
            if (digits_q == DIG_W'(MAX_DIGITS)) begin
              syn_err = 1'b1;
              state_d = S_DISCARD;
            end else begin
              value_d  = {value_q[3:0], nibble};
              digits_d = digits_q + DIG_W'(1);
            end
          end else if (is_eol) begin
            state_d = S_IDLE;
            if (digits_q != '0) issue = 1'b1;
            else                syn_err = 1'b1;
          end else begin
            syn_err = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_NOARG: begin
          if (is_eol) begin
            issue   = 1'b1;
            state_d = S_IDLE;
          end else begin
            syn_err = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_eol) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE) begin
      value_d  = 8'h00;
      digits_d = '0;
    end
  end

  // Registered output values; a no-argument command always carries a zero value field
  always_comb begin
    cmd_valid_d = issue;
    err_d       = syn_err || expire;
    busy_d      = (state_d != S_IDLE);
    cmd_word_d  = cmd_word;
    if (issue)
      cmd_word_d = {opcode_q, 16'h0000, (state_q == S_NOARG) ? 8'h00 : value_q};
  end

endmodule

// File: tb/tb_c2h.sv
// Directed testbench for c2h: command parsing, syntax errors, timeout and reset recovery.
module tb_c2h;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        err;
  logic        busy;

  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;
  int   n_err   = 0;
  logic both_seen = 1'b0;

  c2h #(.TIMEOUT_CYC(16), .MAX_DIGITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (cmd_valid) n_valid++;
    if (err) n_err++;
    if (cmd_valid && err) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns at the falling edge after it was consumed
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_word", cmd_word, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // D3A CRLF
    send("D");
    check("d_busy", busy, 1);
    send_str("3A");
    send(CR);
    check("d3a_valid", cmd_valid, 1);
    check("d3a_word", cmd_word, 32'h0500003A);
    check("d3a_busy", busy, 0);
    send(LF);
    check("lf_no_valid", cmd_valid, 0);
    check("lf_no_err", err, 0);

    // spaces ignored, letter hex digits
    send_str("I 4 2");
    send(CR);
    check("i42_word", cmd_word, 32'h01000042);
    send_str("IFF");
    send(CR);
    check("iff_word", cmd_word, 32'h010000FF);

    send_str("I7");
    send(LF);
    check("i7_word", cmd_word, 32'h01000007);
    send_str("LI");
    send(CR);
    check("li_valid", cmd_valid, 1);
    check("li_word", cmd_word, 32'h04000000);
    repeat (2) @(negedge clk);
    check("count_valid_a", 32'(n_valid), 5);
    check("count_err_a", 32'(n_err), 0);

    // R with a stray argument, then recover
    send("R");
    send("5");
    check("r5_err", err, 1);
    check("r5_no_valid", cmd_valid, 0);
    send(CR);
    check("r5_discard_err", err, 0);
    check("r5_discard_busy", busy, 0);
    send("R");
    send(LF);
    check("r_valid", cmd_valid, 1);
    check("r_word", cmd_word, 32'h02000000);

    // digit overflow and missing digit
    send_str("D12");
    send("3");
    check("overflow_err", err, 1);
    send(CR);
    check("overflow_word", cmd_word, 32'h02000000);
    send("I");
    send(CR);
    check("nodigit_err", err, 1);
    check("nodigit_busy", busy, 0);
    check("nodigit_word", cmd_word, 32'h02000000);
    repeat (2) @(negedge clk);
    check("count_valid_b", 32'(n_valid), 6);
    check("count_err_b", 32'(n_err), 3);

    // idle timeout inside a partial command
    send_str("D3");
    repeat (16) @(negedge clk);
    check("to_early_err", err, 0);
    check("to_early_busy", busy, 1);
    @(negedge clk);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    @(negedge clk);
    check("to_err_pulse", err, 0);
    send_str("LD");
    send(LF);
    check("ld_valid", cmd_valid, 1);
    check("ld_word", cmd_word, 32'h03000000);

    // reset between L and D
    send("L");
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_word", cmd_word, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send("D");
    check("post_rst_busy", busy, 1);
    send(CR);
    check("post_rst_err", err, 1);
    check("post_rst_no_valid", cmd_valid, 0);
    check("post_rst_word", cmd_word, 32'h0);

`ifdef C2H_LOWERCASE_EN
    send_str("ld");
    send(LF);
    check("lc_ld_valid", cmd_valid, 1);
    check("lc_ld_word", cmd_word, 32'h03000000);
`else
    send("l");
    check("lc_l_err", err, 1);
    send("d");
    send(LF);
    check("lc_no_valid", cmd_valid, 0);
    check("lc_busy", busy, 0);
`endif

    repeat (2) @(negedge clk);
    check("valid_err_exclusive", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
